// File: rtl/cpu_mem_pkg.sv
// Shared CPU/data-memory encodings: access sizes, store FSM states and byte-lane masks.
// The load-data extender is meant to use the same size encodings.
package cpu_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam logic [3:0] LANE_NONE    = 4'b0000;
  localparam logic [3:0] LANE_BYTE0   = 4'b0001;
  localparam logic [3:0] LANE_HALF_LO = 4'b0011;
  localparam logic [3:0] LANE_HALF_HI = 4'b1100;
  localparam logic [3:0] LANE_WORD    = 4'b1111;

  function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] replicate_lanes(input logic [31:0] data, input logic [1:0] size);
    logic [31:0] rep;
    case (size)
      SZ_BYTE: rep = {4{data[7:0]}};
      SZ_HALF: rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge: drops right-justified store data into the
// addressed lane(s) of an old word and reports which lanes were written.
module store_lane_merge
  import cpu_mem_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o,
  output logic [3:0]  strobe_o
);

  logic [31:0] rep_s;

  // Lane enables per access size; alignment is rejected before this is used.
  always_comb begin
    case (size_i)
      SZ_BYTE: strobe_o = LANE_BYTE0 << lane_i;
      SZ_HALF: strobe_o = lane_i[1] ? LANE_HALF_HI : LANE_HALF_LO;
      SZ_WORD: strobe_o = LANE_WORD;
      default: strobe_o = LANE_NONE;
    endcase
  end

  // Enabled lanes take the replicated store data, the others keep the old word.
  always_comb begin
    rep_s = replicate_lanes(data_i, size_i);
    for (int b = 0; b < 4; b++) begin
      merged_o[8*b +: 8] = strobe_o[b] ? rep_s[8*b +: 8] : old_word_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store path from the memory stage to a word-wide data RAM; sub-word stores are
// read-modify-write unless SMU_BYTE_STROBE_EN selects direct byte-strobed writes.
module store_merge_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
`ifdef SMU_BYTE_STROBE_EN
  output logic [3:0]        mem_wstrb,
`endif
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);
  // Timer value in the RD_TIMEOUT-th waiting cycle; valid in that cycle still wins.
  localparam logic [TW-1:0] TIMER_LAST = TW'(RD_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        size_q, size_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merged_s;
  logic [3:0]        strobe_s;

  store_lane_merge u_merge (
    .old_word_i (mem_rd_data),
    .data_i     (data_q),
    .size_i     (size_q),
    .lane_i     (addr_q[1:0]),
    .merged_o   (merged_s),
    .strobe_o   (strobe_s)
  );

  // Next-state and capture logic for the store sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    timer_d = timer_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_data;
          size_d  = req_size;
          timer_d = {TW{1'b0}};
          if (access_illegal(req_size, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else begin
            err_d = 1'b0;
`ifdef SMU_BYTE_STROBE_EN
            wdata_d = replicate_lanes(req_data, req_size);
            state_d = ST_WRITE;
`else
            if (req_size == SZ_WORD) begin
              wdata_d = req_data;
              state_d = ST_WRITE;
            end else begin
              wdata_d = 32'h0000_0000;
              state_d = ST_READ;
            end
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        timer_d = {TW{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rd_valid) begin
          wdata_d = merged_s;
          state_d = ST_WRITE;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WRITE: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and captured request; reset abandons any store in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= 32'h0000_0000;
      size_q  <= 2'b00;
      timer_q <= {TW{1'b0}};
      err_q   <= 1'b0;
      wdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign mem_rd_en   = (state_q == ST_READ);
  assign mem_wr_en   = (state_q == ST_WRITE);
  assign done        = (state_q == ST_FIN);
  assign err         = (state_q == ST_FIN) && err_q;
  assign mem_addr    = (state_q == ST_IDLE) ? {ADDR_W{1'b0}} : {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wr_data = (state_q == ST_WRITE) ? wdata_q : 32'h0000_0000;

`ifdef SMU_BYTE_STROBE_EN
  assign mem_wstrb = (state_q == ST_WRITE) ? strobe_s : LANE_NONE;
`else
  logic unused_strobe_s;
  assign unused_strobe_s = ^strobe_s;
`endif

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: directed stores checked every cycle against a
// timeline model of the expected bus activity, plus literal pins per vector.
module tb_store_merge_unit;

  localparam int RD_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        done;
  logic        err;
`ifdef SMU_BYTE_STROBE_EN
  logic [3:0]  mem_wstrb;
  logic [3:0]  wstrb_seen;
  logic [3:0]  m_st;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit act = 1'b0;
  int acc = 0;
  logic [31:0] m_addr, m_wd;
  logic        m_err;
  int          m_rd, m_wr, m_fin;
  int          mem_lat = 0;
  logic [31:0] mem_word = 32'h0;
  int          rd_cnt = 0;

  store_merge_unit #(.ADDR_W(32), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_size     (req_size),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
`ifdef SMU_BYTE_STROBE_EN
    .mem_wstrb    (mem_wstrb),
`endif
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] spec_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [1:0] s, input logic [1:0] lane);
    logic [31:0] mask;
    int sh;
    if (s == 2'b00) begin
      sh = 8 * int'(lane);
      mask = 32'hFF << sh;
      return (old & ~mask) | ((d & 32'hFF) << sh);
    end
    if (s == 2'b01) begin
      sh = 16 * int'(lane[1]);
      mask = 32'hFFFF << sh;
      return (old & ~mask) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  // Expected timeline relative to the accept edge: k=1 is the cycle after accept.
  task automatic plan(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input int lat, input logic [31:0] old);
    logic ill;
    ill = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    m_addr = {a[31:2], 2'b00};
    m_rd = 0; m_wr = 0; m_err = 1'b0; m_wd = 32'h0;
`ifdef SMU_BYTE_STROBE_EN
    m_st = 4'h0;
`endif
    if (ill) begin
      m_fin = 1; m_err = 1'b1;
    end
`ifdef SMU_BYTE_STROBE_EN
    else begin
      m_wr = 1; m_fin = 2;
      m_wd = (s == 2'b00) ? 32'(d[7:0]) * 32'h0101_0101 :
             (s == 2'b01) ? 32'(d[15:0]) * 32'h0001_0001 : d;
      m_st = (s == 2'b00) ? (4'b0001 << a[1:0]) :
             (s == 2'b01) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end
`else
    else if (s == 2'b10) begin
      m_wr = 1; m_fin = 2; m_wd = d;
    end else begin
      m_rd = 1;
      if (lat >= 1 && lat <= RD_TIMEOUT) begin
        m_wr = lat + 2; m_fin = lat + 3; m_wd = spec_merge(old, d, s, a[1:0]);
      end else begin
        m_fin = RD_TIMEOUT + 2; m_err = 1'b1;
      end
    end
`endif
    if (lat < 0) m_fin = m_fin + 0;
  endtask

  // Memory model: answers a read strobe after mem_lat cycles (0 = never).
  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_rd_valid) begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = 32'h0;
      end
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = mem_word;
        end
      end
      if (mem_rd_en && mem_lat > 0) rd_cnt = mem_lat;
    end
  end

  // Compares every DUT output with the model on each falling edge.
  always @(negedge clk) begin : compare
    int k;
    logic e_rdy, e_rd, e_wr, e_done, e_err;
    logic [31:0] e_addr, e_wd;
    if (chk_en) begin
      k = cyc - acc;
      e_rdy = 1'b1; e_rd = 1'b0; e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0;
      e_addr = 32'h0; e_wd = 32'h0;
      if (act && k >= 1 && k <= m_fin) begin
        e_rdy = 1'b0;
        e_addr = m_addr;
        if (k == m_fin) begin e_done = 1'b1; e_err = m_err; end
        if (k == m_wr) begin e_wr = 1'b1; e_wd = m_wd; end
        if (k == m_rd) e_rd = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      chk("mem_addr", mem_addr, e_addr);
      if (e_wr) chk("mem_wr_data", mem_wr_data, e_wd);
`ifdef SMU_BYTE_STROBE_EN
      chk("mem_wstrb", 32'(mem_wstrb), (e_wr ? 32'(m_st) : 32'h0));
`endif
    end
  end

  task automatic start_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                             input int lat, input logic [31:0] old);
    mem_lat = lat; mem_word = old;
    plan(a, d, s, lat, old);
    acc = cyc; act = 1'b1;
    req_addr = a; req_data = d; req_size = s; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~a; req_data = ~d; req_size = ~s;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          input int lat, input logic [31:0] old,
                          output int done_k, output logic [31:0] wr_seen, output logic err_seen);
    start_store(a, d, s, lat, old);
    done_k = -1; wr_seen = 32'h0; err_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (mem_wr_en) begin
        wr_seen = mem_wr_data;
`ifdef SMU_BYTE_STROBE_EN
        wstrb_seen = mem_wstrb;
`endif
      end
      if (done) begin done_k = i; err_seen = err; break; end
      @(negedge clk);
    end
    checks++;
    if (done_k < 0) begin
      errors++;
      $display("FAIL done_wait: got no done within 40 cycles, expected done (addr %h)", a);
    end
    @(negedge clk);
  endtask

  initial begin
    int dk;
    logic [31:0] wv;
    logic ev;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_data = 32'h0; req_size = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_rd_en", 32'(mem_rd_en), 32'h0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wr_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

`ifdef SMU_BYTE_STROBE_EN
    do_store(32'h0000_0003, 32'h0000_005A, 2'b00, 0, 32'h0, dk, wv, ev);
    chk("sb_byte_wdata", wv, 32'h5A5A_5A5A);
    chk("sb_byte_wstrb", 32'(wstrb_seen), 32'h8);
    chk("sb_byte_done_k", 32'(dk), 32'd2);
    chk("sb_byte_err", 32'(ev), 32'h0);
    do_store(32'h0000_0102, 32'h1234_CAFE, 2'b01, 0, 32'h0, dk, wv, ev);
    chk("sb_half_wdata", wv, 32'hCAFE_CAFE);
    chk("sb_half_wstrb", 32'(wstrb_seen), 32'hC);
    chk("sb_half_done_k", 32'(dk), 32'd2);
`else
    do_store(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 0, 32'h0, dk, wv, ev);
    chk("word_wdata", wv, 32'hDEAD_BEEF);
    chk("word_done_k", 32'(dk), 32'd2);
    chk("word_err", 32'(ev), 32'h0);
    do_store(32'h0000_0102, 32'h0000_00AB, 2'b00, 2, 32'h1122_3344, dk, wv, ev);
    chk("byte_wdata", wv, 32'h11AB_3344);
    chk("byte_done_k", 32'(dk), 32'd5);
    chk("byte_err", 32'(ev), 32'h0);
    do_store(32'h0000_0206, 32'h1234_CAFE, 2'b01, 1, 32'hFFFF_FFFF, dk, wv, ev);
    chk("half_hi_wdata", wv, 32'hCAFE_FFFF);
    chk("half_hi_done_k", 32'(dk), 32'd4);
    do_store(32'h0000_0304, 32'h0000_BEEF, 2'b01, RD_TIMEOUT, 32'h0123_4567, dk, wv, ev);
    chk("edge_valid_wdata", wv, 32'h0123_BEEF);
    chk("edge_valid_done_k", 32'(dk), 32'd18);
    chk("edge_valid_err", 32'(ev), 32'h0);
    do_store(32'h0000_000F, 32'hFFFF_FF77, 2'b00, 1, 32'hAABB_CCDD, dk, wv, ev);
    chk("byte_lane3_wdata", wv, 32'h77BB_CCDD);
    do_store(32'h0000_0010, 32'h0000_0005, 2'b00, 3, 32'hFFFF_FFFF, dk, wv, ev);
    chk("byte_lane0_wdata", wv, 32'hFFFF_FF05);
    chk("byte_lane0_done_k", 32'(dk), 32'd6);
    do_store(32'h0000_0300, 32'h0000_0011, 2'b00, 0, 32'h0, dk, wv, ev);
    chk("timeout_done_k", 32'(dk), 32'd17);
    chk("timeout_err", 32'(ev), 32'h1);
    chk("timeout_no_write", wv, 32'h0);
    do_store(32'h0000_0400, 32'h0000_0022, 2'b00, RD_TIMEOUT + 1, 32'h5555_5555, dk, wv, ev);
    chk("late_valid_err", 32'(ev), 32'h1);
    // Reset while waiting for read data: nothing may be written afterwards.
    start_store(32'h0000_0120, 32'h0000_0077, 2'b00, 0, 32'h0);
    repeat (3) @(negedge clk);
    chk("pre_rst_ready", 32'(req_ready), 32'h0);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h1);
    chk("mid_rst_rd_en", 32'(mem_rd_en), 32'h0);
    chk("mid_rst_wr_en", 32'(mem_wr_en), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    act = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (20) @(negedge clk);
    do_store(32'h0000_0040, 32'h0102_0304, 2'b10, 0, 32'h0, dk, wv, ev);
    chk("post_rst_wdata", wv, 32'h0102_0304);
    chk("post_rst_done_k", 32'(dk), 32'd2);
`endif
    do_store(32'h0000_0207, 32'h0000_CAFE, 2'b01, 1, 32'hFFFF_FFFF, dk, wv, ev);
    chk("half_misalign_done_k", 32'(dk), 32'd1);
    chk("half_misalign_err", 32'(ev), 32'h1);
    chk("half_misalign_no_write", wv, 32'h0);
    do_store(32'h0000_0020, 32'h0000_0099, 2'b11, 1, 32'h0, dk, wv, ev);
    chk("illegal_size_err", 32'(ev), 32'h1);
    do_store(32'h0000_0102, 32'hDEAD_BEEF, 2'b10, 0, 32'h0, dk, wv, ev);
    chk("word_misalign_err", 32'(ev), 32'h1);
    do_store(32'h0000_0044, 32'hA5A5_0F0F, 2'b10, 0, 32'h0, dk, wv, ev);
    chk("word2_wdata", wv, 32'hA5A5_0F0F);
    chk("word2_err", 32'(ev), 32'h0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1, "time limit");
  end

endmodule
